// File: rtl/background_idx_fetch_if.sv
// background_idx_fetch_if: scan position in, ROM address/data, pixel-aligned colour index out
interface background_idx_fetch_if #(
    parameter int ADDR_W = 17
);
    logic              pix_ce;
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic [8:0]        scroll_x;
    logic [ADDR_W-1:0] rom_addr;
    logic [2:0]        rom_data;
    logic [2:0]        color_idx;
    logic              idx_active;
    logic [9:0]        out_x;
    logic [9:0]        out_y;
    modport slave (
        input  pix_ce, DrawX, DrawY, scroll_x, rom_data,
        output rom_addr, color_idx, idx_active, out_x, out_y
    );
    modport master (
        output pix_ce, DrawX, DrawY, scroll_x, rom_data,
        input  rom_addr, color_idx, idx_active, out_x, out_y
    );
endinterface

// File: rtl/background_idx_fetch.sv
// background_idx_fetch: 2x-upscaled background ROM fetch with frame-latched horizontal scroll
module background_idx_fetch #(
    parameter int         IMG_W     = 320,
    parameter int         IMG_H     = 240,
    parameter int         ADDR_W    = 17,
    parameter logic [2:0] BLANK_IDX = 3'b001
) (
    input logic                  Clk,
    input logic                  Reset_n,
    background_idx_fetch_if.slave bus
);
    logic [8:0]        scroll_q;
    logic              active;
    logic              act_q;
    logic [9:0]        sum;
    logic [9:0]        sx;
    logic [8:0]        sy;
    logic [9:0]        x_q;
    logic [9:0]        y_q;
    logic [ADDR_W-1:0] addr;
    always_comb begin
        active = bus.DrawX < 10'(2 * IMG_W) && bus.DrawY < 10'(2 * IMG_H);
        sum    = {1'b0, bus.DrawX[9:1]} + {1'b0, scroll_q};
        sx     = sum >= 10'(IMG_W) ? sum - 10'(IMG_W) : sum;
        sy     = bus.DrawY[9:1];
        addr   = (ADDR_W'(sy) << 8) + (ADDR_W'(sy) << 6) + ADDR_W'(sx);
    end
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            scroll_q       <= '0;
            bus.rom_addr   <= '0;
            act_q          <= 1'b0;
            x_q            <= '0;
            y_q            <= '0;
            bus.color_idx  <= BLANK_IDX;
            bus.idx_active <= 1'b0;
            bus.out_x      <= '0;
            bus.out_y      <= '0;
        end else if (bus.pix_ce) begin
            // new scroll only takes effect from the pixel after (0,0) so a frame never tears
            if (bus.DrawX == 10'd0 && bus.DrawY == 10'd0)
                scroll_q <= bus.scroll_x >= 9'(IMG_W) ? 9'(IMG_W - 1) : bus.scroll_x;
            bus.rom_addr   <= active ? addr : '0;
            act_q          <= active;
            x_q            <= bus.DrawX;
            y_q            <= bus.DrawY;
            bus.color_idx  <= act_q ? bus.rom_data : BLANK_IDX;
            bus.idx_active <= act_q;
            bus.out_x      <= x_q;
            bus.out_y      <= y_q;
        end
    end
endmodule

// File: tb/tb_background_idx_fetch.sv
// tb_background_idx_fetch: random scan positions against a per-pixel arithmetic model with a 2-pulse history
module tb_background_idx_fetch;
    localparam int N = 76800;
    typedef struct packed {
        int addr;
        bit act;
        int x;
        int y;
    } rec_t;
    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    logic [2:0] rom_mem [0:N-1];
    rec_t h0 = '0;
    rec_t h1 = '0;
    int m_scroll = 0;
    int checks = 0;
    int failures = 0;
    background_idx_fetch_if bus();
    background_idx_fetch dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));
    always #10 Clk = ~Clk;
    always @(posedge Clk) bus.rom_data <= (bus.rom_addr < N) ? rom_mem[bus.rom_addr] : 3'd0;
    function automatic rec_t mk(input int x, input int y, input int sc);
        rec_t r;
        r.act  = x < 640 && y < 480;
        r.addr = r.act ? (y / 2) * 320 + (x / 2 + sc) % 320 : 0;
        r.x    = x;
        r.y    = y;
        return r;
    endfunction
    // h0 = most recent pulse (drives rom_addr), h1 = the one before (drives colour outputs)
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            h0       <= '0;
            h1       <= '0;
            m_scroll <= 0;
        end else if (bus.pix_ce) begin
            h1 <= h0;
            h0 <= mk(int'(bus.DrawX), int'(bus.DrawY), m_scroll);
            if (bus.DrawX == 10'd0 && bus.DrawY == 10'd0)
                m_scroll <= bus.scroll_x > 9'd319 ? 319 : int'(bus.scroll_x);
        end
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    always @(negedge Clk) begin
        chk("rom_addr", 32'(bus.rom_addr), h0.addr);
        chk("color_idx", 32'(bus.color_idx), h1.act ? 32'(rom_mem[h1.addr]) : 32'd1);
        chk("idx_active", 32'(bus.idx_active), 32'(h1.act));
        chk("out_x", 32'(bus.out_x), h1.x);
        chk("out_y", 32'(bus.out_y), h1.y);
    end
    task automatic pulse(input int x, input int y, input int sc);
        repeat ($urandom_range(0, 2)) @(negedge Clk);
        @(negedge Clk);
        bus.DrawX    = 10'(x);
        bus.DrawY    = 10'(y);
        bus.scroll_x = 9'(sc);
        bus.pix_ce   = 1'b1;
        @(negedge Clk);
        bus.pix_ce = 1'b0;
    endtask
    initial begin
        for (int i = 0; i < N; i++) rom_mem[i] = 3'($urandom_range(0, 7));
        rom_mem[965] = 3'b101;
        bus.pix_ce   = 1'b0;
        bus.DrawX    = '0;
        bus.DrawY    = '0;
        bus.scroll_x = '0;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("reset_addr", 32'(bus.rom_addr), 0);
        chk("reset_color", 32'(bus.color_idx), 1);
        chk("reset_active", 32'(bus.idx_active), 0);
        pulse(10, 6, 0);
        chk("latency_addr", 32'(bus.rom_addr), 965);
        pulse(12, 6, 0);
        chk("latency_color", 32'(bus.color_idx), 5);
        chk("latency_active", 32'(bus.idx_active), 1);
        chk("latency_x", 32'(bus.out_x), 10);
        chk("latency_y", 32'(bus.out_y), 6);
        pulse(0, 0, 100);
        pulse(500, 0, 100);
        chk("wrap_500", 32'(bus.rom_addr), 30);
        pulse(438, 0, 100);
        chk("wrap_438", 32'(bus.rom_addr), 319);
        pulse(500, 100, 200);
        chk("frame_hold_scroll", 32'(bus.rom_addr), 16030);
        pulse(500, 524, 200);
        pulse(0, 0, 200);
        pulse(500, 0, 0);
        chk("frame_new_scroll", 32'(bus.rom_addr), 130);
        pulse(0, 0, 0);
        pulse(639, 479, 0);
        chk("last_pixel", 32'(bus.rom_addr), 76799);
        pulse(700, 479, 0);
        chk("blank_addr", 32'(bus.rom_addr), 0);
        pulse(700, 100, 0);
        chk("blank_color", 32'(bus.color_idx), 1);
        chk("blank_active", 32'(bus.idx_active), 0);
        pulse(20, 10, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            bus.DrawX = 10'($urandom_range(0, 799));
        end
        @(negedge Clk);
        chk("hold_addr", 32'(bus.rom_addr), 1610);
        chk("hold_y", 32'(bus.out_y), 100);
        pulse(0, 0, 400);
        pulse(4, 0, 0);
        chk("clamp", 32'(bus.rom_addr), 1);
        pulse(0, 0, 100);
        pulse(100, 100, 100);
        #3 Reset_n = 1'b0;
        #1;
        chk("async_addr", 32'(bus.rom_addr), 0);
        chk("async_color", 32'(bus.color_idx), 1);
        chk("async_active", 32'(bus.idx_active), 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        pulse(500, 0, 100);
        chk("post_reset_scroll", 32'(bus.rom_addr), 250);
        chk("post_reset_active", 32'(bus.idx_active), 0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0)
                pulse(0, 0, $urandom_range(0, 511));
            else
                pulse($urandom_range(0, 799), $urandom_range(0, 524), $urandom_range(0, 511));
        end
        @(negedge Clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
